// File: rtl/ppu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ppu_bus_arbiter_if
//   Groups the requester handshakes and the VRAM pad signals of the PPU bus
//   arbiter into one bundle.
//
//   Render requester : ren_req, ren_addr -> ren_gnt, ren_valid, ren_rdata
//   CPU requester    : cpu_req, cpu_we, cpu_addr, cpu_wdata
//                      -> cpu_busy, cpu_done, cpu_rdata
//   VRAM pads        : ad_out, ad_oe, ale, rd_n, wr_n (driven), ad_in (sampled)
//
//   master : requester / pad side (drives requests and ad_in)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface ppu_bus_arbiter_if #(
    parameter int ADDR_W = 14
);
    logic              ren_req;
    logic [ADDR_W-1:0] ren_addr;
    logic              ren_gnt;
    logic              ren_valid;
    logic [7:0]        ren_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_busy;
    logic              cpu_done;
    logic [7:0]        cpu_rdata;

    logic [ADDR_W-1:0] ad_out;
    logic              ad_oe;
    logic [7:0]        ad_in;
    logic              ale;
    logic              rd_n;
    logic              wr_n;

    modport master (
        output ren_req, ren_addr,
        input  ren_gnt, ren_valid, ren_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_done, cpu_rdata,
        input  ad_out, ad_oe, ale, rd_n, wr_n,
        output ad_in
    );

    modport slave (
        input  ren_req, ren_addr,
        output ren_gnt, ren_valid, ren_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_done, cpu_rdata,
        output ad_out, ad_oe, ale, rd_n, wr_n,
        input  ad_in
    );
endinterface

// File: rtl/ppu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ppu_bus_arbiter
//   Owns the PPU's multiplexed VRAM bus and arbitrates between render fetches
//   and CPU $2007 accesses. Every access is a LATCH period (ale high, address
//   on AD) followed by a STROBE period (rd_n or wr_n low). Render normally
//   wins; after STARVE_MAX render grants with a CPU request waiting, the CPU
//   is forced through.
//
//   Ports
//     clk_i   : system clock
//     rst_ni  : asynchronous active-low reset
//     ce_i    : PPU tick enable, all state advances only when high
//     bus     : ppu_bus_arbiter_if.slave (requester handshakes + VRAM pads)
// ---------------------------------------------------------------------------
module ppu_bus_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ce_i,
    ppu_bus_arbiter_if.slave       bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_STROBE
    } state_e;

    state_e            state_q, state_d;

    // Access currently on the bus
    logic              cur_cpu_q, cur_cpu_d;
    logic              cur_we_q, cur_we_d;
    logic [7:0]        cur_wdata_q, cur_wdata_d;

    // Single-entry CPU slot; stays full until its STROBE ends
    logic              slot_full_q, slot_full_d;
    logic              slot_we_q, slot_we_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [7:0]        slot_wdata_q, slot_wdata_d;

    logic [SW-1:0]     starve_q, starve_d;

    logic              ren_gnt_q, ren_gnt_d;
    logic              ren_valid_q, ren_valid_d;
    logic [7:0]        ren_rdata_q, ren_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;

    logic              ale_q, ale_d;
    logic              rd_n_q, rd_n_d;
    logic              wr_n_q, wr_n_d;
    logic              ad_oe_q, ad_oe_d;
    logic [ADDR_W-1:0] ad_out_q, ad_out_d;

    logic              cpu_pending;
    logic              arb_en;
    logic              ren_win;

    // A CPU request is only a candidate for arbitration while it waits in
    // the slot, not while it is the access on the bus.
    assign cpu_pending = slot_full_q && !(cur_cpu_q && (state_q != S_IDLE));

    always_comb begin
        state_d      = state_q;
        cur_cpu_d    = cur_cpu_q;
        cur_we_d     = cur_we_q;
        cur_wdata_d  = cur_wdata_q;
        slot_full_d  = slot_full_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        starve_d     = starve_q;
        ren_gnt_d    = 1'b0;
        ren_valid_d  = 1'b0;
        ren_rdata_d  = ren_rdata_q;
        cpu_done_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        ale_d        = ale_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        ad_oe_d      = ad_oe_q;
        ad_out_d     = ad_out_q;
        arb_en       = 1'b0;
        ren_win      = 1'b0;

        // New CPU request is captured only into an empty slot; arbitration
        // below still sees the old slot state, so it waits one turn.
        if (bus.cpu_req && !slot_full_q) begin
            slot_full_d  = 1'b1;
            slot_we_d    = bus.cpu_we;
            slot_addr_d  = bus.cpu_addr;
            slot_wdata_d = bus.cpu_wdata;
        end

        unique case (state_q)
            S_IDLE: begin
                arb_en = 1'b1;
            end
            S_LATCH: begin
                state_d = S_STROBE;
                ale_d   = 1'b0;
                if (cur_we_q) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = {{(ADDR_W-8){1'b0}}, cur_wdata_q};
                end else begin
                    rd_n_d  = 1'b0;
                    ad_oe_d = 1'b0;
                end
            end
            S_STROBE: begin
                state_d = S_IDLE;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                ad_oe_d = 1'b0;
                if (cur_cpu_q) begin
                    cpu_done_d  = 1'b1;
                    slot_full_d = 1'b0;
                    if (!cur_we_q) begin
                        cpu_rdata_d = bus.ad_in;
                    end
                end else begin
                    ren_valid_d = 1'b1;
                    ren_rdata_d = bus.ad_in;
                end
                arb_en = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (arb_en) begin
            ren_win = bus.ren_req && !(cpu_pending && (starve_q == STARVE_LIM));
            if (ren_win) begin
                state_d   = S_LATCH;
                cur_cpu_d = 1'b0;
                cur_we_d  = 1'b0;
                ren_gnt_d = 1'b1;
                ale_d     = 1'b1;
                ad_oe_d   = 1'b1;
                ad_out_d  = bus.ren_addr;
                if (cpu_pending && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 1'b1;
                end
            end else if (cpu_pending) begin
                state_d     = S_LATCH;
                cur_cpu_d   = 1'b1;
                cur_we_d    = slot_we_q;
                cur_wdata_d = slot_wdata_q;
                starve_d    = '0;
                ale_d       = 1'b1;
                ad_oe_d     = 1'b1;
                ad_out_d    = slot_addr_q;
            end
        end
    end

    // Reset aborts any access at once: strobes and bus drive release
    // asynchronously and the CPU slot is emptied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cur_cpu_q    <= 1'b0;
            cur_we_q     <= 1'b0;
            cur_wdata_q  <= '0;
            slot_full_q  <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            starve_q     <= '0;
            ren_gnt_q    <= 1'b0;
            ren_valid_q  <= 1'b0;
            ren_rdata_q  <= '0;
            cpu_done_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            ale_q        <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            ad_oe_q      <= 1'b0;
            ad_out_q     <= '0;
        end else if (ce_i) begin
            state_q      <= state_d;
            cur_cpu_q    <= cur_cpu_d;
            cur_we_q     <= cur_we_d;
            cur_wdata_q  <= cur_wdata_d;
            slot_full_q  <= slot_full_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            starve_q     <= starve_d;
            ren_gnt_q    <= ren_gnt_d;
            ren_valid_q  <= ren_valid_d;
            ren_rdata_q  <= ren_rdata_d;
            cpu_done_q   <= cpu_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ale_q        <= ale_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            ad_oe_q      <= ad_oe_d;
            ad_out_q     <= ad_out_d;
        end
    end

    assign bus.ren_gnt   = ren_gnt_q;
    assign bus.ren_valid = ren_valid_q;
    assign bus.ren_rdata = ren_rdata_q;
    assign bus.cpu_busy  = slot_full_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ale       = ale_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.ad_oe     = ad_oe_q;
    assign bus.ad_out    = ad_out_q;

endmodule

// File: tb/tb_ppu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ppu_bus_arbiter
//   Directed bench for ppu_bus_arbiter. Stimulus pushes expected bus events
//   and read data into queues; a monitor on the falling clock edge pops and
//   compares whenever the DUT shows a bus phase, ren_valid or cpu_done.
//   The VRAM model returns ad_in = latched_addr[7:0] ^ 8'h5A.
// ---------------------------------------------------------------------------
module tb_ppu_bus_arbiter;

    localparam int ADDR_W = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;

    ppu_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ppu_bus_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ce_i   (ce),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus event: {kind[1:0], addr/data[13:0], oe}; kind 1=latch 2=read strobe 3=write strobe
    logic [16:0] exp_bus[$];
    logic [7:0]  exp_ren[$];
    logic [7:0]  exp_cpu[$];

    int   gnt_busy_cnt = 0;
    int   done_cnt     = 0;
    int   cyc          = 0;
    int   last_gnt_cyc = 0;
    logic ce_prev      = 1'b0;
    logic [7:0] ad_in_r = 8'h00;

    assign bus.ad_in = ad_in_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] ev_latch(input logic [13:0] a);
        return {2'd1, a, 1'b1};
    endfunction
    function automatic logic [16:0] ev_rd();
        return {2'd2, 14'd0, 1'b0};
    endfunction
    function automatic logic [16:0] ev_wr(input logic [7:0] d);
        return {2'd3, 6'd0, d, 1'b1};
    endfunction

    always @(posedge clk) ce_prev <= ce & rst_n;

    // VRAM model and monitor
    always @(negedge clk) begin
        logic [1:0]  k;
        logic [16:0] obs;
        if (bus.ale) ad_in_r = bus.ad_out[7:0] ^ 8'h5A;
        if (ce_prev && rst_n) begin
            cyc++;
            if (bus.ale || !bus.rd_n || !bus.wr_n) begin
                if (bus.ale && bus.rd_n && bus.wr_n)       k = 2'd1;
                else if (!bus.ale && !bus.rd_n && bus.wr_n) k = 2'd2;
                else if (!bus.ale && bus.rd_n && !bus.wr_n) k = 2'd3;
                else                                        k = 2'd0;
                obs = {k, (k == 2'd2) ? 14'd0 : bus.ad_out, bus.ad_oe};
                if (exp_bus.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected: got=0x%0h want=none", obs);
                end else begin
                    chk("bus_event", 32'(obs), 32'(exp_bus.pop_front()));
                end
            end
            if (bus.ren_valid) begin
                chk("ren_latency", 32'(cyc - last_gnt_cyc), 32'd2);
                if (exp_ren.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ren_valid_unexpected: got=0x%0h want=none", bus.ren_rdata);
                end else begin
                    chk("ren_rdata", 32'(bus.ren_rdata), 32'(exp_ren.pop_front()));
                end
            end
            if (bus.cpu_done) begin
                done_cnt++;
                chk("busy_fall", 32'(bus.cpu_busy), 32'd0);
                if (exp_cpu.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cpu_done_unexpected: got=0x%0h want=none", bus.cpu_rdata);
                end else begin
                    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu.pop_front()));
                end
            end
            if (bus.ren_gnt) begin
                last_gnt_cyc = cyc;
                if (bus.cpu_busy) gnt_busy_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string nm);
        int i;
        for (i = 0; i < 40; i++) begin
            step();
            if (bus.ren_gnt) break;
        end
        if (i == 40) begin
            total++; bad++;
            $display("FAIL %s: got=no_gnt want=gnt", nm);
        end
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_bus.size() == 0 && exp_ren.size() == 0 &&
                exp_cpu.size() == 0 && !bus.cpu_busy) break;
            step();
        end
        if (i == 200) begin
            total++; bad++;
            $display("FAIL %s: got=pending want=drained", nm);
        end
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        bus.ren_req   = 1'b0;
        bus.ren_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        ce            = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ale",   32'(bus.ale),       32'd0);
        chk("rst_rd_n",  32'(bus.rd_n),      32'd1);
        chk("rst_wr_n",  32'(bus.wr_n),      32'd1);
        chk("rst_ad_oe", 32'(bus.ad_oe),     32'd0);
        chk("rst_ad_out",32'(bus.ad_out),    32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_busy",  32'(bus.cpu_busy),  32'd0);
        chk("rst_gnt",   32'(bus.ren_gnt),   32'd0);
        rst_n = 1'b1;
        step();

        // 1: single render read of 0x2000, VRAM returns 0x5A
        exp_bus.push_back(ev_latch(14'h2000));
        exp_bus.push_back(ev_rd());
        exp_ren.push_back(8'h5A);
        bus.ren_addr = 14'h2000;
        bus.ren_req  = 1'b1;
        wait_gnt("t1_gnt");
        bus.ren_req  = 1'b0;
        drain("t1_drain");

        // 2: CPU write 0x3F00 <- 0x0F
        d0 = done_cnt;
        exp_bus.push_back(ev_latch(14'h3F00));
        exp_bus.push_back(ev_wr(8'h0F));
        exp_cpu.push_back(8'h00);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h3F00;
        bus.cpu_wdata = 8'h0F;
        step();
        bus.cpu_req   = 1'b0;
        chk("t2_busy_rise", 32'(bus.cpu_busy), 32'd1);
        drain("t2_drain");
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 3: render held high, one CPU read of 0x23C0 after the first grant
        d0 = gnt_busy_cnt;
        for (int i = 0; i < 5; i++) begin
            exp_bus.push_back(ev_latch(14'h10A5));
            exp_bus.push_back(ev_rd());
            exp_ren.push_back(8'hFF);
        end
        exp_bus.push_back(ev_latch(14'h23C0));
        exp_bus.push_back(ev_rd());
        exp_cpu.push_back(8'h9A);
        exp_bus.push_back(ev_latch(14'h10A5));
        exp_bus.push_back(ev_rd());
        exp_ren.push_back(8'hFF);
        bus.ren_addr = 14'h10A5;
        bus.ren_req  = 1'b1;
        wait_gnt("t3_gnt");
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 14'h23C0;
        step();
        bus.cpu_req  = 1'b0;
        n = 1;
        for (int i = 0; i < 60 && n < 6; i++) begin
            step();
            if (bus.ren_gnt) begin
                n++;
                if (n == 6) chk("t3_no_bubble", 32'(bus.cpu_done), 32'd1);
            end
        end
        bus.ren_req = 1'b0;
        chk("t3_grant_total", 32'(n), 32'd6);
        drain("t3_drain");
        chk("t3_starve_grants", 32'(gnt_busy_cnt - d0), 32'd4);

        // 4: second cpu_req while busy is dropped
        d0 = done_cnt;
        exp_bus.push_back(ev_latch(14'h0123));
        exp_bus.push_back(ev_rd());
        exp_cpu.push_back(8'h79);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 14'h0123;
        step();
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h0456;
        bus.cpu_wdata = 8'hAA;
        step();
        bus.cpu_req   = 1'b0;
        chk("t4_busy_hold", 32'(bus.cpu_busy), 32'd1);
        drain("t4_drain");
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 5: reset during write STROBE
        exp_bus.push_back(ev_latch(14'h0200));
        exp_bus.push_back(ev_wr(8'h33));
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h0200;
        bus.cpu_wdata = 8'h33;
        step();
        bus.cpu_req   = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.wr_n) begin n = 1; break; end
            step();
        end
        chk("t5_saw_strobe", 32'(n), 32'd1);
        @(negedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_n_async", 32'(bus.wr_n),  32'd1);
        chk("t5_oe_async",   32'(bus.ad_oe), 32'd0);
        chk("t5_busy_clr",   32'(bus.cpu_busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("t5_no_done",  32'(done_cnt - d0), 32'd0);
        chk("t5_rdata",    32'(bus.cpu_rdata), 32'd0);
        chk("t5_idle_ale", 32'(bus.ale), 32'd0);
        chk("t5_q_empty",  32'(exp_bus.size()), 32'd0);

        // 6: CE low for 10 CLKs in the middle of LATCH
        exp_bus.push_back(ev_latch(14'h0777));
        exp_bus.push_back(ev_rd());
        exp_ren.push_back(8'h2D);
        bus.ren_addr = 14'h0777;
        bus.ren_req  = 1'b1;
        wait_gnt("t6_gnt");
        bus.ren_req  = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_ale_hold",  32'(bus.ale),    32'd1);
            chk("t6_addr_hold", 32'(bus.ad_out), 32'h0777);
        end
        ce = 1'b1;
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
